// File: rtl/id_ex_stage.sv
// id_ex_stage: one-entry ID/EX pipeline register with operand selection.
// Decodes a MIPS-format word into ALU operands and a writeback target.
// The entry is held stable under downstream backpressure.
// Optional build macro ID_EX_FWD_EN adds writeback forwarding, both at
// capture and into a held entry. Without the macro, the wb_* inputs are ignored.
module id_ex_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        wb_we,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] alu_rs1,
    output logic [31:0] alu_rs2,
    output logic [5:0]  alu_opcode,
    output logic [5:0]  alu_funct,
    output logic [4:0]  dst_addr,
    output logic        dst_we
);

    typedef enum logic [2:0] {
        OpReg,
        OpSext,
        OpZext,
        OpShamt,
        OpLui,
        OpOther
    } op_class_e;

    // Instruction fields
    logic [5:0]  w_opcode;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [5:0]  w_funct;
    logic [15:0] w_imm16;

    assign w_opcode = instr[31:26];
    assign w_rs     = instr[25:21];
    assign w_rt     = instr[20:16];
    assign w_rd     = instr[15:11];
    assign w_funct  = instr[5:0];
    assign w_imm16  = instr[15:0];

    // Held entry state
    logic        r_out_valid;
    logic [31:0] r_alu_rs1;
    logic [31:0] r_alu_rs2;
    logic [5:0]  r_alu_opcode;
    logic [5:0]  r_alu_funct;
    logic [4:0]  r_dst_addr;
    logic        r_dst_we;
    logic [4:0]  r_rs_addr;
    logic [4:0]  r_rt_addr;
    logic        r_rs_reg;
    logic        r_rt_reg;

    // Decode results
    op_class_e   w_class;
    logic        w_src1_reg;
    logic        w_src2_reg;
    logic [31:0] w_imm_op;
    logic [4:0]  w_dst_addr;
    logic        w_dst_we;
    logic [31:0] w_rs_val;
    logic [31:0] w_rt_val;
    logic [31:0] w_op1;
    logic [31:0] w_op2;
    logic        w_capture;

    assign in_ready  = !r_out_valid || out_ready;
    assign w_capture = in_valid && in_ready;

    // Classify the opcode into an operand-selection group
    always_comb begin
        w_class = OpOther;
        case (w_opcode)
            6'b000000:                       w_class = OpReg;
            6'b001000, 6'b001001:            w_class = OpSext;
            6'b010000, 6'b010001, 6'b010010: w_class = OpZext;
            6'b011000, 6'b011001, 6'b011010: w_class = OpShamt;
            6'b110000:                       w_class = OpLui;
            default:                         w_class = OpOther;
        endcase
    end

    // Derive immediate operand, source kinds and writeback target from the class
    always_comb begin
        w_imm_op   = 32'h0;
        w_src1_reg = 1'b1;
        w_src2_reg = 1'b0;
        w_dst_addr = w_rt;
        w_dst_we   = 1'b1;
        case (w_class)
            OpReg: begin
                w_src2_reg = 1'b1;
                w_dst_addr = w_rd;
            end
            OpSext:  w_imm_op = {{16{w_imm16[15]}}, w_imm16};
            OpZext:  w_imm_op = {16'h0, w_imm16};
            OpShamt: w_imm_op = {27'h0, w_imm16[4:0]};
            OpLui: begin
                w_src1_reg = 1'b0;
                w_imm_op   = {16'h0, w_imm16};
            end
            default: begin
                // Unknown opcodes take register operands but never write back
                w_src2_reg = 1'b1;
                w_dst_addr = w_rd;
                w_dst_we   = 1'b0;
            end
        endcase
        if (w_dst_addr == 5'd0) begin
            w_dst_we = 1'b0;
        end
    end

    // Register operand values: r0 reads zero, optional capture-time forwarding
    always_comb begin
        w_rs_val = (w_rs == 5'd0) ? 32'h0 : rs_data;
        w_rt_val = (w_rt == 5'd0) ? 32'h0 : rt_data;
`ifdef ID_EX_FWD_EN
        if (wb_we && (wb_addr != 5'd0) && (wb_addr == w_rs)) begin
            w_rs_val = wb_data;
        end
        if (wb_we && (wb_addr != 5'd0) && (wb_addr == w_rt)) begin
            w_rt_val = wb_data;
        end
`endif
        w_op1 = w_src1_reg ? w_rs_val : 32'h0;
        w_op2 = w_src2_reg ? w_rt_val : w_imm_op;
    end

`ifndef ID_EX_FWD_EN
    // Writeback inputs and stored source info only matter when forwarding is built in
    logic w_unused_fwd;
    assign w_unused_fwd = ^{wb_we, wb_addr, wb_data, r_rs_addr, r_rt_addr, r_rs_reg, r_rt_reg};
`endif

    // Entry register: capture, drain, or hold (with optional in-place forwarding)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_alu_rs1    <= 32'h0;
            r_alu_rs2    <= 32'h0;
            r_alu_opcode <= 6'h0;
            r_alu_funct  <= 6'h0;
            r_dst_addr   <= 5'h0;
            r_dst_we     <= 1'b0;
            r_rs_addr    <= 5'h0;
            r_rt_addr    <= 5'h0;
            r_rs_reg     <= 1'b0;
            r_rt_reg     <= 1'b0;
        end else if (w_capture) begin
            r_out_valid  <= 1'b1;
            r_alu_rs1    <= w_op1;
            r_alu_rs2    <= w_op2;
            r_alu_opcode <= w_opcode;
            r_alu_funct  <= w_funct;
            r_dst_addr   <= w_dst_addr;
            r_dst_we     <= w_dst_we;
            r_rs_addr    <= w_rs;
            r_rt_addr    <= w_rt;
            r_rs_reg     <= w_src1_reg;
            r_rt_reg     <= w_src2_reg;
        end else begin
            if (out_ready) begin
                r_out_valid <= 1'b0;
            end
`ifdef ID_EX_FWD_EN
            // Only register-sourced operands track later writebacks
            if (r_out_valid && wb_we && (wb_addr != 5'd0)) begin
                if (r_rs_reg && (wb_addr == r_rs_addr)) begin
                    r_alu_rs1 <= wb_data;
                end
                if (r_rt_reg && (wb_addr == r_rt_addr)) begin
                    r_alu_rs2 <= wb_data;
                end
            end
`endif
        end
    end

    assign out_valid  = r_out_valid;
    assign alu_rs1    = r_alu_rs1;
    assign alu_rs2    = r_alu_rs2;
    assign alu_opcode = r_alu_opcode;
    assign alu_funct  = r_alu_funct;
    assign dst_addr   = r_dst_addr;
    assign dst_we     = r_dst_we;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed and randomized checks of id_ex_stage
// against a behavioural model of the stage.
module tb_id_ex_stage;

`ifdef ID_EX_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] instr = 32'h0;
    logic [31:0] rs_data = 32'h0;
    logic [31:0] rt_data = 32'h0;
    logic        wb_we = 1'b0;
    logic [4:0]  wb_addr = 5'h0;
    logic [31:0] wb_data = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] alu_rs1;
    logic [31:0] alu_rs2;
    logic [5:0]  alu_opcode;
    logic [5:0]  alu_funct;
    logic [4:0]  dst_addr;
    logic        dst_we;

    int checks = 0;
    int errors = 0;

    id_ex_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .instr      (instr),
        .rs_data    (rs_data),
        .rt_data    (rt_data),
        .wb_we      (wb_we),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .alu_rs1    (alu_rs1),
        .alu_rs2    (alu_rs2),
        .alu_opcode (alu_opcode),
        .alu_funct  (alu_funct),
        .dst_addr   (dst_addr),
        .dst_we     (dst_we)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [5:0]  opc;
        logic [5:0]  fn;
        logic [4:0]  dst;
        logic        we;
        logic [4:0]  rsa;
        logic [4:0]  rta;
        logic        rsr;
        logic        rtr;
    } ent_t;

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'b000000, rs, rt, rd, 5'b00000, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // Value a register source contributes at capture time
    function automatic logic [31:0] reg_val(input logic [4:0] a, input logic [31:0] d,
                                            input logic wbwe, input logic [4:0] wba,
                                            input logic [31:0] wbd);
        if (a == 5'd0) return 32'h0;
        if (FWD && wbwe && wba == a) return wbd;
        return d;
    endfunction

    // Expected bundle for one instruction
    function automatic ent_t ref_decode(input logic [31:0] ins, input logic [31:0] rsd,
                                        input logic [31:0] rtd, input logic wbwe,
                                        input logic [4:0] wba, input logic [31:0] wbd);
        ent_t        e;
        logic [5:0]  op;
        logic [15:0] imm;
        logic [31:0] immop;
        logic        known;
        op  = ins[31:26];
        imm = ins[15:0];
        e.opc = op;
        e.fn  = ins[5:0];
        e.rsa = ins[25:21];
        e.rta = ins[20:16];
        immop = 32'h0;
        known = 1'b1;
        if (op == 6'h08 || op == 6'h09)                      immop = {{16{imm[15]}}, imm};
        else if (op == 6'h10 || op == 6'h11 || op == 6'h12)  immop = {16'h0, imm};
        else if (op == 6'h18 || op == 6'h19 || op == 6'h1A)  immop = {27'h0, imm[4:0]};
        else if (op == 6'h30)                                immop = {16'h0, imm};
        else if (op != 6'h00)                                known = 1'b0;
        e.rsr = (op != 6'h30);
        e.rtr = (op == 6'h00) || !known;
        e.rs1 = e.rsr ? reg_val(e.rsa, rsd, wbwe, wba, wbd) : 32'h0;
        e.rs2 = e.rtr ? reg_val(e.rta, rtd, wbwe, wba, wbd) : immop;
        e.dst = e.rtr ? ins[15:11] : ins[20:16];
        e.we  = known && (e.dst != 5'd0);
        return e;
    endfunction

    // Present one instruction for a single accepted cycle, then idle the input
    task automatic issue(input logic [31:0] ins, input logic [31:0] rsd, input logic [31:0] rtd,
                         input logic wbwe, input logic [4:0] wba, input logic [31:0] wbd);
        @(negedge clk);
        instr    = ins;
        rs_data  = rsd;
        rt_data  = rtd;
        wb_we    = wbwe;
        wb_addr  = wba;
        wb_data  = wbd;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        wb_we    = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({out_valid, dst_we, alu_rs1, alu_rs2, alu_opcode, alu_funct, dst_addr} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got v=%b we=%b rs1=%h rs2=%h op=%h fn=%h dst=%h exp all 0",
                     out_valid, dst_we, alu_rs1, alu_rs2, alu_opcode, alu_funct, dst_addr);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got %b exp 1", in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        issue(rtype(5'd1, 5'd2, 5'd3, 6'b001000), 32'd10, 32'd20, 1'b0, 5'd0, 32'h0);
        checks++;
        if ({out_valid, alu_rs1, alu_rs2, dst_addr, dst_we, alu_opcode, alu_funct} !==
            {1'b1, 32'h0000000A, 32'h00000014, 5'd3, 1'b1, 6'h00, 6'b001000}) begin
            errors++;
            $display("FAIL add got v=%b rs1=%h rs2=%h dst=%0d we=%b op=%h fn=%h exp 1 A 14 3 1 0 8",
                     out_valid, alu_rs1, alu_rs2, dst_addr, dst_we, alu_opcode, alu_funct);
        end
    endtask

    task automatic test_imm();
        issue(itype(6'h08, 5'd1, 5'd4, 16'hFFFB), 32'd20, 32'h12345678, 1'b0, 5'd0, 32'h0);
        checks++;
        if ({alu_rs1, alu_rs2, dst_addr, dst_we} !== {32'h14, 32'hFFFFFFFB, 5'd4, 1'b1}) begin
            errors++;
            $display("FAIL addi got rs1=%h rs2=%h dst=%0d we=%b exp 14 FFFFFFFB 4 1",
                     alu_rs1, alu_rs2, dst_addr, dst_we);
        end
        issue(itype(6'h11, 5'd1, 5'd5, 16'h8000), 32'd20, 32'h0, 1'b0, 5'd0, 32'h0);
        checks++;
        if ({alu_rs2, dst_addr} !== {32'h00008000, 5'd5}) begin
            errors++;
            $display("FAIL ori got rs2=%h dst=%0d exp 00008000 5", alu_rs2, dst_addr);
        end
        issue(itype(6'h1A, 5'd6, 5'd7, 16'hFFFF), 32'h55, 32'h99, 1'b0, 5'd0, 32'h0);
        checks++;
        if ({alu_rs1, alu_rs2, dst_addr, dst_we} !== {32'h55, 32'h1F, 5'd7, 1'b1}) begin
            errors++;
            $display("FAIL shamt got rs1=%h rs2=%h dst=%0d we=%b exp 55 1F 7 1",
                     alu_rs1, alu_rs2, dst_addr, dst_we);
        end
    endtask

    task automatic test_lui();
        issue(itype(6'h30, 5'd1, 5'd9, 16'hABCD), 32'h12345678, 32'h0, 1'b0, 5'd0, 32'h0);
        checks++;
        if ({alu_rs1, alu_rs2, alu_opcode, dst_addr, dst_we} !==
            {32'h0, 32'h0000ABCD, 6'b110000, 5'd9, 1'b1}) begin
            errors++;
            $display("FAIL lui got rs1=%h rs2=%h op=%b dst=%0d we=%b exp 0 ABCD 110000 9 1",
                     alu_rs1, alu_rs2, alu_opcode, dst_addr, dst_we);
        end
    endtask

    task automatic test_zero_reg();
        issue(rtype(5'd0, 5'd2, 5'd0, 6'h20), 32'hFFFFFFFF, 32'h33, 1'b0, 5'd0, 32'h0);
        checks++;
        if ({alu_rs1, alu_rs2, dst_we} !== {32'h0, 32'h33, 1'b0}) begin
            errors++;
            $display("FAIL zero_reg got rs1=%h rs2=%h we=%b exp 0 33 0", alu_rs1, alu_rs2, dst_we);
        end
        issue(itype(6'h3F, 5'd3, 5'd0, 16'h2825), 32'h44, 32'hFFFFFFFF, 1'b0, 5'd0, 32'h0);
        checks++;
        if ({alu_opcode, alu_funct, alu_rs1, alu_rs2, dst_addr, dst_we} !==
            {6'h3F, 6'h25, 32'h44, 32'h0, 5'd5, 1'b0}) begin
            errors++;
            $display("FAIL unknown_op got op=%h fn=%h rs1=%h rs2=%h dst=%0d we=%b exp 3F 25 44 0 5 0",
                     alu_opcode, alu_funct, alu_rs1, alu_rs2, dst_addr, dst_we);
        end
    endtask

    task automatic test_fwd();
        logic [31:0] exp_rs1;
        logic [31:0] exp_rs2;
        exp_rs1 = FWD ? 32'h63 : 32'h5;
        exp_rs2 = FWD ? 32'h7 : 32'h3;
        @(negedge clk);
        instr    = rtype(5'd1, 5'd2, 5'd3, 6'h20);
        rs_data  = 32'd5;
        rt_data  = 32'd3;
        wb_we    = 1'b1;
        wb_addr  = 5'd1;
        wb_data  = 32'd99;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        wb_we     = 1'b1;
        wb_addr   = 5'd2;
        wb_data   = 32'd7;
        checks++;
        if (alu_rs1 !== exp_rs1) begin
            errors++;
            $display("FAIL fwd_capture got rs1=%h exp %h", alu_rs1, exp_rs1);
        end
        @(negedge clk);
        wb_we = 1'b0;
        checks++;
        if ({out_valid, in_ready, alu_rs1, alu_rs2} !== {1'b1, 1'b0, exp_rs1, exp_rs2}) begin
            errors++;
            $display("FAIL fwd_held got v=%b rdy=%b rs1=%h rs2=%h exp 1 0 %h %h",
                     out_valid, in_ready, alu_rs1, alu_rs2, exp_rs1, exp_rs2);
        end
        out_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_stall();
        issue(rtype(5'd4, 5'd5, 5'd6, 6'h22), 32'hAA, 32'hBB, 1'b0, 5'd0, 32'h0);
        out_ready = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, dst_we, alu_rs1, alu_rs2, dst_addr} !== '0) begin
            errors++;
            $display("FAIL reset_stall got v=%b we=%b rs1=%h rs2=%h dst=%0d exp all 0",
                     out_valid, dst_we, alu_rs1, alu_rs2, dst_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready got %b exp 1", in_ready);
        end
        out_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_random();
        ent_t        m;
        bit          mv;
        logic        exp_rdy;
        logic [5:0]  ops [10];
        ops = '{6'h00, 6'h08, 6'h09, 6'h10, 6'h11, 6'h12, 6'h18, 6'h19, 6'h1A, 6'h30};
        mv = 1'b0;
        m  = ref_decode(32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        for (int cyc = 0; cyc < 400; cyc++) begin
            checks++;
            if (out_valid !== mv) begin
                errors++;
                $display("FAIL rand_valid cyc %0d got %b exp %b", cyc, out_valid, mv);
            end else if (mv) begin
                checks++;
                if ({alu_rs1, alu_rs2, alu_opcode, alu_funct, dst_addr, dst_we} !==
                    {m.rs1, m.rs2, m.opc, m.fn, m.dst, m.we}) begin
                    errors++;
                    $display("FAIL rand_bundle cyc %0d got %h %h %h %h %0d %b exp %h %h %h %h %0d %b",
                             cyc, alu_rs1, alu_rs2, alu_opcode, alu_funct, dst_addr, dst_we,
                             m.rs1, m.rs2, m.opc, m.fn, m.dst, m.we);
                end
            end
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            instr     = $urandom;
            if ($urandom_range(0, 4) != 0) instr[31:26] = ops[$urandom_range(0, 9)];
            instr[25:21] = 5'($urandom_range(0, 3));
            instr[20:16] = 5'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) instr[15:11] = 5'd0;
            rs_data = $urandom;
            rt_data = $urandom;
            wb_we   = $urandom_range(0, 1);
            wb_addr = 5'($urandom_range(0, 3));
            wb_data = $urandom;
            #1;
            exp_rdy = !mv || out_ready;
            checks++;
            if (in_ready !== exp_rdy) begin
                errors++;
                $display("FAIL rand_ready cyc %0d got %b exp %b", cyc, in_ready, exp_rdy);
            end
            if (in_valid && exp_rdy) begin
                m  = ref_decode(instr, rs_data, rt_data, wb_we, wb_addr, wb_data);
                mv = 1'b1;
            end else begin
                if (out_ready) mv = 1'b0;
                if (FWD && mv && wb_we && wb_addr != 5'd0) begin
                    if (m.rsr && wb_addr == m.rsa) m.rs1 = wb_data;
                    if (m.rtr && wb_addr == m.rta) m.rs2 = wb_data;
                end
            end
            @(negedge clk);
        end
        in_valid  = 1'b0;
        wb_we     = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_add();
        test_imm();
        test_lui();
        test_zero_reg();
        test_fwd();
        test_reset_mid_stall();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have port clk, input, 1, single rising-edge clock for all state.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port in_valid, input, 1, decode offers an instruction this cycle.
REQ-004 SHALL have port in_ready, output, 1, stage accepts the offer this cycle.
REQ-005 SHALL have port instr, input, 32, MIPS-format word: opcode[31:26], rs[25:21], rt[20:16], rd[15:11], funct[5:0], imm16[15:0].
REQ-006 SHALL have port rs_data, input, 32, register-file read of instr rs field.
REQ-007 SHALL have port rt_data, input, 32, register-file read of instr rt field.
REQ-008 SHALL have port wb_we, input, 1, writeback write enable.
REQ-009 SHALL have port wb_addr, input, 5, writeback destination register.
REQ-010 SHALL have port wb_data, input, 32, writeback value.
REQ-011 SHALL have port out_valid, output, 1, ALU operand bundle is valid.
REQ-012 SHALL have port out_ready, input, 1, downstream ALU/EX consumes the bundle.
REQ-013 SHALL have ports alu_rs1 and alu_rs2, output, 32 each, registered ALU operands.
REQ-014 SHALL have ports alu_opcode and alu_funct, output, 6 each, registered copies of instr opcode/funct.
REQ-015 SHALL have ports dst_addr (output, 5) and dst_we (output, 1), registered writeback target.

Function
REQ-016 SHALL hold one entry: in_ready = !out_valid || out_ready (combinational); capture on in_valid && in_ready; latency exactly 1 cycle.
REQ-017 SHALL set out_valid=1 on capture; clear it when out_ready && !in_valid; hold all outputs stable while out_valid && !out_ready.
REQ-018 R-type (opcode 000000): alu_rs1=rs operand, alu_rs2=rt operand, dst_addr=rd, dst_we=1.
REQ-019 opcodes 001000/001001: alu_rs2 = sign-extended imm16; alu_rs1=rs operand; dst_addr=rt; dst_we=1.
REQ-020 opcodes 010000/010001/010010: alu_rs2 = zero-extended imm16; alu_rs1=rs operand; dst_addr=rt; dst_we=1.
REQ-021 opcodes 011000/011001/011010: alu_rs2 = {27'b0, imm16[4:0]}; alu_rs1=rs operand; dst_addr=rt; dst_we=1.
REQ-022 opcode 110000 (LUI): alu_rs1=0, alu_rs2 = zero-extended imm16; dst_addr=rt; dst_we=1.
REQ-023 any other opcode: pass through opcode/funct, operands per R-type rule, dst_we=0.
REQ-024 register 0 as a source SHALL read 0 regardless of rs_data/rt_data/forwarding.
REQ-025 dst_we SHALL be forced 0 when dst_addr==0.
REQ-026 SHALL store source addresses and per-operand "register-sourced" flags alongside the held entry.

Reset
REQ-027 rst_n low SHALL immediately clear out_valid, dst_we and zero alu_rs1, alu_rs2, alu_opcode, alu_funct, dst_addr and stored source state.
REQ-028 reset asserted mid-stall SHALL discard the held entry; first cycle after release in_ready=1.

Configuration
REQ-029 With ID_EX_FWD_EN defined: at capture, if wb_we && wb_addr!=0 && wb_addr equals a register-sourced field, that operand SHALL take wb_data instead of rs_data/rt_data.
REQ-030 With ID_EX_FWD_EN defined: while an entry is held, a matching writeback (same rule) SHALL overwrite the held register-sourced operand next edge; immediate operands never change.
REQ-031 Without ID_EX_FWD_EN: wb_we/wb_addr/wb_data SHALL be ignored; operands come only from rs_data/rt_data/immediate.

Verification
REQ-032 ADD: instr opcode 000000 rs=1 rt=2 rd=3 funct 001000, rs_data=10, rt_data=20, out_ready=1 -> next cycle out_valid=1, alu_rs1=0000000A, alu_rs2=00000014, dst_addr=3, dst_we=1.
REQ-033 ADDI rs=1 rt=4 imm16=FFFB, rs_data=20 -> alu_rs1=00000014, alu_rs2=FFFFFFFB, dst_addr=4; ORI imm16=8000 -> alu_rs2=00008000.
REQ-034 LUI imm16=ABCD rs_data=12345678 -> alu_rs1=00000000, alu_rs2=0000ABCD, alu_opcode=110000.
REQ-035 Forwarding (macro on): capture rs=1 rs_data=5 with wb_we=1 wb_addr=1 wb_data=99 -> alu_rs1=00000063; then out_ready=0, wb write addr=rt(2) data=7 -> held alu_rs2=00000007, in_ready=0; macro off -> operands unchanged.
REQ-036 R-type rd=0 or rs=0 with rs_data=FFFFFFFF -> dst_we=0, alu_rs1=0; rst_n pulsed low during stall -> out_valid=0 immediately, in_ready=1 after release.
